// File: rtl/huff_decoder.sv
// Bit-serial Huffman decoder: shifts MSB-first stream bits against a loaded
// code table and emits one symbol per matched code over a valid/ready port.
module huff_decoder #(
  parameter int unsigned MAX_CHAR_COUNT = 5,
  parameter int unsigned CODE_W         = MAX_CHAR_COUNT
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             load,
  input  logic [3:0]                       char_count,
  input  logic [MAX_CHAR_COUNT*8-1:0]      character,
  input  logic [MAX_CHAR_COUNT*CODE_W-1:0] encoded_value,
  input  logic [MAX_CHAR_COUNT*CODE_W-1:0] encoded_mask,
  input  logic                             bit_valid,
  input  logic                             bit_in,
  input  logic                             bit_last,
  output logic                             bit_ready,
  output logic                             char_valid,
  output logic [7:0]                       char_out,
  input  logic                             char_ready,
  output logic [7:0]                       dec_count,
  output logic                             done,
  output logic                             error
);

  localparam int unsigned CHR_W = MAX_CHAR_COUNT * 8;
  localparam int unsigned TAB_W = MAX_CHAR_COUNT * CODE_W;
  localparam int unsigned LEN_W = $clog2(CODE_W + 1);
  localparam int unsigned CNT_W = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SHIFT = 3'd1,
    EMIT  = 3'd2,
    DONE  = 3'd3,
    ERR   = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [CHR_W-1:0]   chr_tab_q, chr_tab_d;
  logic [TAB_W-1:0]   val_tab_q, val_tab_d;
  logic [TAB_W-1:0]   msk_tab_q, msk_tab_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CODE_W-1:0]  acc_q, acc_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               last_q, last_d;
  logic [7:0]         char_out_q, char_out_d;
  logic               char_valid_q, char_valid_d;
  logic               bit_ready_q, bit_ready_d;
  logic [7:0]         dec_count_q, dec_count_d;
  logic               done_q, done_d;
  logic               error_q, error_d;

  logic [CODE_W-1:0]  acc_nxt;
  logic [LEN_W-1:0]   len_nxt;
  logic [CODE_W-1:0]  len_mask;
  logic               hit;
  logic [7:0]         hit_chr;

  // Candidate code after the offered bit, and the table lookup against it
  always_comb begin
    acc_nxt  = CODE_W'({acc_q, bit_in});
    len_nxt  = len_q + LEN_W'(1);
    len_mask = '0;
    hit      = 1'b0;
    hit_chr  = 8'h00;
    for (int unsigned b = 0; b < CODE_W; b++) begin
      if (LEN_W'(b) < len_nxt) begin
        len_mask[b] = 1'b1;
      end
    end
    // Descending scan so the lowest matching index is the one left standing
    for (int i = int'(MAX_CHAR_COUNT) - 1; i >= 0; i--) begin
      if ((CNT_W'(i) < cnt_q) &&
          (msk_tab_q[i*CODE_W +: CODE_W] == len_mask) &&
          ((val_tab_q[i*CODE_W +: CODE_W] & len_mask) == acc_nxt)) begin
        hit     = 1'b1;
        hit_chr = chr_tab_q[i*8 +: 8];
      end
    end
    // A single-entry table has nothing to distinguish: every bit is a symbol
    if (cnt_q == CNT_W'(1)) begin
      hit     = 1'b1;
      hit_chr = chr_tab_q[7:0];
    end
  end

  // Next-state and registered-output computation
  always_comb begin
    state_d      = state_q;
    chr_tab_d    = chr_tab_q;
    val_tab_d    = val_tab_q;
    msk_tab_d    = msk_tab_q;
    cnt_d        = cnt_q;
    acc_d        = acc_q;
    len_d        = len_q;
    last_d       = last_q;
    char_out_d   = char_out_q;
    char_valid_d = char_valid_q;
    dec_count_d  = dec_count_q;

    case (state_q)
      SHIFT: begin
        if (bit_valid && bit_ready_q) begin
          if (hit) begin
            char_out_d   = hit_chr;
            char_valid_d = 1'b1;
            acc_d        = '0;
            len_d        = '0;
            last_d       = bit_last;
            state_d      = EMIT;
          end else if ((len_nxt == LEN_W'(CODE_W)) || bit_last) begin
            state_d = ERR;
          end else begin
            acc_d = acc_nxt;
            len_d = len_nxt;
          end
        end
      end
      EMIT: begin
        if (char_valid_q && char_ready) begin
          char_valid_d = 1'b0;
          if (dec_count_q != 8'hFF) begin
            dec_count_d = dec_count_q + 8'd1;
          end
          state_d = last_q ? DONE : SHIFT;
        end
      end
      default: begin
        state_d = state_q;
      end
    endcase

    // Table load overrides whatever the FSM was doing
    if (load) begin
      chr_tab_d    = character;
      val_tab_d    = encoded_value;
      msk_tab_d    = encoded_mask;
      cnt_d        = char_count;
      acc_d        = '0;
      len_d        = '0;
      last_d       = 1'b0;
      char_valid_d = 1'b0;
      dec_count_d  = 8'h00;
      if ((char_count == CNT_W'(0)) || (char_count > CNT_W'(MAX_CHAR_COUNT))) begin
        state_d = ERR;
      end else begin
        state_d = SHIFT;
      end
    end

    bit_ready_d = (state_d == SHIFT);
    done_d      = (state_d == DONE);
    error_d     = (state_d == ERR);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      chr_tab_q    <= '0;
      val_tab_q    <= '0;
      msk_tab_q    <= '0;
      cnt_q        <= '0;
      acc_q        <= '0;
      len_q        <= '0;
      last_q       <= 1'b0;
      char_out_q   <= 8'h00;
      char_valid_q <= 1'b0;
      bit_ready_q  <= 1'b0;
      dec_count_q  <= 8'h00;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      chr_tab_q    <= chr_tab_d;
      val_tab_q    <= val_tab_d;
      msk_tab_q    <= msk_tab_d;
      cnt_q        <= cnt_d;
      acc_q        <= acc_d;
      len_q        <= len_d;
      last_q       <= last_d;
      char_out_q   <= char_out_d;
      char_valid_q <= char_valid_d;
      bit_ready_q  <= bit_ready_d;
      dec_count_q  <= dec_count_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  assign bit_ready  = bit_ready_q;
  assign char_valid = char_valid_q;
  assign char_out   = char_out_q;
  assign dec_count  = dec_count_q;
  assign done       = done_q;
  assign error      = error_q;

endmodule

// File: tb/tb_huff_decoder.sv
// Scoreboard bench for huff_decoder: a prefix-matching reference decoder fills
// an expected-symbol queue, and a sink process checks every emitted symbol.
module tb_huff_decoder;

  localparam int unsigned MAXC = 5;
  localparam int unsigned CW   = 5;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 load;
  logic [3:0]           char_count;
  logic [MAXC*8-1:0]    character;
  logic [MAXC*CW-1:0]   encoded_value;
  logic [MAXC*CW-1:0]   encoded_mask;
  logic                 bit_valid;
  logic                 bit_in;
  logic                 bit_last;
  logic                 bit_ready;
  logic                 char_valid;
  logic [7:0]           char_out;
  logic                 char_ready;
  logic [7:0]           dec_count;
  logic                 done;
  logic                 error;

  huff_decoder #(.MAX_CHAR_COUNT(MAXC), .CODE_W(CW)) dut (
    .clk(clk), .reset(reset), .load(load), .char_count(char_count),
    .character(character), .encoded_value(encoded_value), .encoded_mask(encoded_mask),
    .bit_valid(bit_valid), .bit_in(bit_in), .bit_last(bit_last), .bit_ready(bit_ready),
    .char_valid(char_valid), .char_out(char_out), .char_ready(char_ready),
    .dec_count(dec_count), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int sink_mode = 0;          // 0 always ready, 1 random, 2 stalled
  int exp_q[$];

  int t_cnt;
  int t_len[MAXC];
  int t_val[MAXC];
  int t_chr[MAXC];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Sink: picks char_ready for the coming edge, then scores the handshake
  always @(negedge clk) begin
    case (sink_mode)
      0:       char_ready = 1'b1;
      1:       char_ready = ($urandom_range(0, 2) != 0);
      default: char_ready = 1'b0;
    endcase
    if (reset) begin
      if (char_valid && char_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_symbol: got %0d, expected none", char_out);
        end else begin
          check("char_out", int'(char_out), exp_q.pop_front());
        end
      end else if (char_valid) begin
        check("stall_bit_ready", int'(bit_ready), 0);
        if (exp_q.size() > 0) check("stall_char_out", int'(char_out), exp_q[0]);
      end
    end
  end

  task automatic drive_table();
    for (int i = 0; i < int'(MAXC); i++) begin
      character[i*8 +: 8]       = 8'(t_chr[i]);
      encoded_value[i*CW +: CW] = CW'(t_val[i]);
      encoded_mask[i*CW +: CW]  = CW'((1 << t_len[i]) - 1);
    end
    // A one-entry table must decode regardless of its mask
    if (t_cnt == 1) encoded_mask[CW-1:0] = CW'($urandom);
    char_count = 4'(t_cnt);
  endtask

  task automatic do_load();
    drive_table();
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  // Reference decoder: grow a prefix bit by bit, first table entry of equal
  // length and value wins; status 1 = clean end, 2 = failure
  task automatic model_run(input int bits[$], output int nsend, output int status,
                           output int nsym);
    int acc, l, hit;
    bit last;
    acc = 0; l = 0; nsend = 0; status = 0; nsym = 0;
    if (t_cnt < 1 || t_cnt > int'(MAXC)) begin
      status = 2;
      return;
    end
    for (int k = 0; k < bits.size(); k++) begin
      acc = acc * 2 + bits[k];
      l++;
      nsend++;
      last = (k == bits.size() - 1);
      hit = -1;
      if (t_cnt == 1) hit = 0;
      else
        for (int i = t_cnt - 1; i >= 0; i--)
          if (t_len[i] == l && (t_val[i] % (1 << l)) == acc) hit = i;
      if (hit >= 0) begin
        exp_q.push_back(t_chr[hit]);
        nsym++;
        acc = 0;
        l = 0;
        if (last) begin
          status = 1;
          return;
        end
      end else if (l == int'(CW) || last) begin
        status = 2;
        return;
      end
    end
  endtask

  task automatic send_bit(input int b, input bit last);
    int g = 0;
    bit_valid = 1'b1;
    bit_in    = 1'(b);
    bit_last  = last;
    while (!bit_ready && g < 500) begin
      @(negedge clk);
      g++;
    end
    if (g >= 500) begin
      n_tests++;
      n_fail++;
      $display("FAIL bit_accept_timeout: got bit_ready=0, expected 1");
    end else begin
      @(negedge clk);
    end
    bit_valid = 1'b0;
    bit_last  = 1'b0;
  endtask

  task automatic wait_end(input int status, input int nsym);
    int g = 0;
    while (!(done || error) && g < 3000) begin
      @(negedge clk);
      g++;
    end
    if (g >= 3000) begin
      n_tests++;
      n_fail++;
      $display("FAIL end_timeout: got done=%0d error=%0d, expected an end state", done, error);
    end
    check("done", int'(done), (status == 1) ? 1 : 0);
    check("error", int'(error), (status == 2) ? 1 : 0);
    check("dec_count", int'(dec_count), (nsym > 255) ? 255 : nsym);
    check("end_bit_ready", int'(bit_ready), 0);
    check("pending_symbols", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic run_stream(input int bits[$]);
    int nsend, status, nsym;
    model_run(bits, nsend, status, nsym);
    for (int k = 0; k < nsend; k++) send_bit(bits[k], k == bits.size() - 1);
    wait_end(status, nsym);
  endtask

  task automatic table_anu();
    t_cnt = 3;
    t_len = '{1, 2, 2, 3, 4};
    t_val = '{0, 2, 3, 5, 9};
    t_chr = '{97, 110, 117, 120, 121};
  endtask

  initial begin
    int bits[$];
    int nsend, status, nsym;
    reset = 1'b0; load = 1'b0; bit_valid = 1'b0; bit_in = 1'b0; bit_last = 1'b0;
    char_count = 4'd0; character = '0; encoded_value = '0; encoded_mask = '0;
    repeat (3) @(negedge clk);
    check("rst_char_valid", int'(char_valid), 0);
    check("rst_char_out", int'(char_out), 0);
    check("rst_bit_ready", int'(bit_ready), 0);
    check("rst_dec_count", int'(dec_count), 0);
    check("rst_done", int'(done), 0);
    check("rst_error", int'(error), 0);
    reset = 1'b1;
    // IDLE ignores bits until a table is loaded
    bit_valid = 1'b1; bit_in = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("idle_bit_ready", int'(bit_ready), 0);
      check("idle_char_valid", int'(char_valid), 0);
    end
    bit_valid = 1'b0;

    // Basic three-symbol stream
    sink_mode = 0;
    table_anu();
    do_load();
    check("load_bit_ready", int'(bit_ready), 1);
    bits = '{0, 1, 0, 1, 1};
    run_stream(bits);

    // Sink stalls three cycles after the first symbol
    do_load();
    sink_mode = 2;
    model_run(bits, nsend, status, nsym);
    send_bit(0, 1'b0);
    repeat (3) begin
      check("stall_valid", int'(char_valid), 1);
      check("stall_out_a", int'(char_out), 97);
      check("stall_ready", int'(bit_ready), 0);
      @(negedge clk);
    end
    sink_mode = 0;
    send_bit(1, 1'b0); send_bit(0, 1'b0); send_bit(1, 1'b0); send_bit(1, 1'b1);
    wait_end(1, 3);

    // Code overflow with no symbol
    t_cnt = 2;
    do_load();
    bits = '{1, 1, 1, 1, 1};
    run_stream(bits);

    // Truncated code, then reload recovers
    table_anu();
    do_load();
    bits = '{1};
    run_stream(bits);
    do_load();
    check("reload_error", int'(error), 0);
    check("reload_bit_ready", int'(bit_ready), 1);
    bits = '{1, 1, 0};
    run_stream(bits);

    // Single-entry table
    t_cnt = 1;
    do_load();
    bits = '{1, 0};
    run_stream(bits);

    // Invalid counts
    t_cnt = 0;
    do_load();
    run_stream(bits);
    t_cnt = 9;
    do_load();
    run_stream(bits);

    // Reset while a symbol is pending
    table_anu();
    do_load();
    sink_mode = 2;
    exp_q.push_back(110);
    send_bit(1, 1'b0);
    send_bit(0, 1'b0);
    check("pre_rst_valid", int'(char_valid), 1);
    check("pre_rst_out", int'(char_out), 110);
    reset = 1'b0;
    exp_q.delete();
    @(negedge clk);
    reset = 1'b1;
    check("midrst_char_valid", int'(char_valid), 0);
    check("midrst_char_out", int'(char_out), 0);
    check("midrst_bit_ready", int'(bit_ready), 0);
    check("midrst_done", int'(done), 0);
    check("midrst_error", int'(error), 0);
    sink_mode = 0;
    bit_valid = 1'b1; bit_in = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("postrst_bit_ready", int'(bit_ready), 0);
      check("postrst_char_valid", int'(char_valid), 0);
      check("postrst_dec_count", int'(dec_count), 0);
    end
    bit_valid = 1'b0;

    // dec_count saturation
    t_cnt = 1;
    do_load();
    bits.delete();
    for (int k = 0; k < 260; k++) bits.push_back(int'($urandom_range(0, 1)));
    run_stream(bits);

    // Randomized tables and streams
    sink_mode = 1;
    for (int it = 0; it < 150; it++) begin
      t_cnt = ($urandom_range(0, 9) == 0) ? int'($urandom_range(6, 15)) * int'($urandom_range(0, 1))
                                          : int'($urandom_range(1, MAXC));
      for (int i = 0; i < int'(MAXC); i++) begin
        t_len[i] = int'($urandom_range(1, CW));
        t_val[i] = int'($urandom_range(0, (1 << t_len[i]) - 1));
        t_chr[i] = int'($urandom_range(33, 126));
      end
      do_load();
      bits.delete();
      if (t_cnt >= 1 && t_cnt <= int'(MAXC)) begin
        for (int s = 0; s < int'($urandom_range(1, 6)); s++) begin
          int idx;
          idx = int'($urandom_range(0, t_cnt - 1));
          for (int b = t_len[idx] - 1; b >= 0; b--) bits.push_back((t_val[idx] >> b) & 1);
        end
      end
      if (bits.size() == 0 || $urandom_range(0, 3) == 0)
        for (int e = 0; e < int'($urandom_range(1, 3)); e++) bits.push_back(int'($urandom_range(0, 1)));
      run_stream(bits);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
